// File: rtl/updn_counter_pkg.sv
// Shared constants for the up/down modulo counter: direction encodings
// and parameter legality limits.
package updn_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

    localparam int   WIDTH_MIN = 2;
    localparam int   WIDTH_MAX = 16;

endpackage

// File: rtl/updn_next_calc.sv
// Combinational next-count calculator for updn_mod_counter.
// Returns the count that an enabled edge would produce and whether that
// edge hits a boundary (MODULUS-1 going up, 0 going down).
// Build option: UPDN_MOD_COUNTER_SAT_EN selects saturation (hold at the
// boundary) instead of wrap-around.
module updn_next_calc
    import updn_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             updn,
    output logic [WIDTH-1:0] nxt,
    output logic             hit
);

    // Arithmetic is one bit wider than the count so MODULUS = 2**WIDTH
    // cannot alias its top value onto zero.
    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] cur;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;
    logic [WIDTH:0] sum;
    logic           unused_msb;

    assign cur = {1'b0, count};
    assign inc = cur + ONE;
    assign dec = cur - ONE;

    // Select the next value by direction, applying the boundary policy.
    always_comb begin
        hit = 1'b0;
        sum = cur;
        if (updn == DIR_UP) begin
            hit = (cur == TOP);
`ifdef UPDN_MOD_COUNTER_SAT_EN
            sum = hit ? cur : inc;
`else
            sum = hit ? '0 : inc;
`endif
        end else begin
            hit = (cur == '0);
`ifdef UPDN_MOD_COUNTER_SAT_EN
            sum = hit ? cur : dec;
`else
            sum = hit ? TOP : dec;
`endif
        end
    end

    // Result always lies in 0..MODULUS-1, so the extension bit is zero.
    assign nxt        = sum[WIDTH-1:0];
    assign unused_msb = sum[WIDTH];

endmodule

// File: rtl/updn_mod_counter.sv
// Up/down modulo-MODULUS counter with synchronous clamped load and a
// registered terminal-count pulse.
// Priority each edge: LOAD, then EN, then hold.
// Build option: UPDN_MOD_COUNTER_SAT_EN -- saturate at the boundaries
// (TC flags each blocked count) instead of wrapping (TC flags each wrap).
module updn_mod_counter
    import updn_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             UPDN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC
);

    // Reject illegal configurations while elaborating.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("updn_mod_counter: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("updn_mod_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP_W = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] nxt;
    logic             hit;
    logic [WIDTH-1:0] load_clamped;

    updn_next_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .count (COUNT),
        .updn  (UPDN),
        .nxt   (nxt),
        .hit   (hit)
    );

    // Out-of-range load values clamp to the top of the count range.
    always_comb begin
        load_clamped = LOAD_VAL;
        if ({1'b0, LOAD_VAL} >= MOD_X)
            load_clamped = TOP_W;
    end

    // Count and TC registers; loads and holds never raise TC.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            COUNT <= '0;
            TC    <= 1'b0;
        end else if (LOAD) begin
            COUNT <= load_clamped;
            TC    <= 1'b0;
        end else if (EN) begin
            COUNT <= nxt;
            TC    <= hit;
        end else begin
            TC    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updn_mod_counter.sv
// Directed + random bench for updn_mod_counter with an expected-value
// scoreboard fed by a behavioural reference model.
module tb_updn_mod_counter;

    localparam int WIDTH = 4;
`ifdef UPDN_MOD_COUNTER_SAT_EN
    localparam int MOD = 16;
`else
    localparam int MOD = 10;
`endif

    typedef struct {
        int    c;
        int    t;
        string tag;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             EN = 1'b0;
    logic             UPDN = 1'b1;
    logic             LOAD = 1'b0;
    logic [WIDTH-1:0] LOAD_VAL = '0;
    logic [WIDTH-1:0] COUNT;
    logic             TC;

    int   ncmp = 0;
    int   nfail = 0;
    int   mc = 0;
    int   mt = 0;
    exp_t sb[$];

    updn_mod_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .EN       (EN),
        .UPDN     (UPDN),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .COUNT    (COUNT),
        .TC       (TC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int ec, input int et);
        ncmp++;
        assert (int'(COUNT) === ec) else begin
            nfail++;
            $error("FAIL %s COUNT got %0d want %0d", tag, COUNT, ec);
        end
        ncmp++;
        assert (int'(TC) === et) else begin
            nfail++;
            $error("FAIL %s TC got %0d want %0d", tag, TC, et);
        end
    endtask

    // Reference model of one clock edge.
    task automatic model(input logic en, input logic updn, input logic load, input int lv);
        if (load) begin
            mc = (lv >= MOD) ? MOD - 1 : lv;
            mt = 0;
        end else if (en) begin
            mt = 0;
            if (updn) begin
                if (mc == MOD - 1) begin
                    mt = 1;
`ifndef UPDN_MOD_COUNTER_SAT_EN
                    mc = 0;
`endif
                end else mc = mc + 1;
            end else begin
                if (mc == 0) begin
                    mt = 1;
`ifndef UPDN_MOD_COUNTER_SAT_EN
                    mc = MOD - 1;
`endif
                end else mc = mc - 1;
            end
        end else begin
            mt = 0;
        end
    endtask

    // Drive one edge's inputs, queue the model's prediction, compare after the edge.
    task automatic step(input logic en, input logic updn, input logic load, input int lv, input string tag);
        exp_t e;
        @(negedge CLK);
        EN = en; UPDN = updn; LOAD = load; LOAD_VAL = WIDTH'(lv);
        model(en, updn, load, lv);
        e.c = mc; e.t = mt; e.tag = tag;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            nfail++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check(e.tag, e.c, e.t);
        end
    endtask

    // Pull reset low between edges and check that it acts before the next edge.
    task automatic async_reset(input string tag);
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        mc = 0; mt = 0;
        check(tag, 0, 0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        EN = 1'b0; LOAD = 1'b0;
        RESET_N = 1'b1;
    endtask

    initial begin
        // Reset held for two edges.
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset", 0, 0);
        release_reset();

`ifdef UPDN_MOD_COUNTER_SAT_EN
        // Saturation at the top, then release downward.
        step(0, 1, 1, 14, "sat_load14");
        step(1, 1, 0, 0, "sat_up15");
        step(1, 1, 0, 0, "sat_blk1");
        step(1, 1, 0, 0, "sat_blk2");
        step(1, 0, 0, 0, "sat_dn14");
        // Saturation at the bottom.
        step(0, 0, 1, 1, "sat_load1");
        step(1, 0, 0, 0, "sat_dn0");
        step(1, 0, 0, 0, "sat_blk0");
        step(0, 0, 0, 0, "sat_hold");
        step(1, 1, 0, 0, "sat_up1");
`else
        // Up-count through one wrap.
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, "up_cnt");
        check("up_end", 2, 0);

        // Down-count from reset.
        async_reset("rst_before_dn");
        release_reset();
        step(1, 0, 0, 0, "dn_wrap0");
        check("dn_first", 9, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, "dn_cnt");
        check("dn_second_wrap", 9, 1);

        // Load priority and clamping.
        step(0, 1, 1, 4, "load4");
        step(1, 0, 1, 7, "load7_en");
        check("load7_lit", 7, 0);
        step(1, 1, 1, 12, "load12_clamp");
        check("load12_lit", 9, 0);
        step(1, 1, 1, 15, "load15_clamp");
        step(0, 0, 1, 0, "load0_boundary");

        // Hold then direction flip each cycle.
        step(0, 1, 1, 5, "load5");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "hold");
        check("hold_lit", 5, 0);
        step(1, 1, 0, 0, "flip_up");
        step(1, 0, 0, 0, "flip_dn");
        step(1, 1, 0, 0, "flip_up2");
        check("flip_lit", 6, 0);

        // Async reset mid-count at 6.
        async_reset("async_mid");
        release_reset();

        // Wrap then hold: TC must drop on the hold cycle.
        step(0, 1, 1, 9, "load9");
        step(1, 1, 0, 0, "wrap_up");
        check("wrap_up_lit", 0, 1);
        step(0, 1, 0, 0, "hold_after_wrap");

        // TC high when reset hits must clear immediately.
        step(0, 1, 1, 9, "load9b");
        step(1, 1, 0, 0, "wrap_up_b");
        async_reset("async_tc_clear");
`endif

        // Reset held across an edge with LOAD asserted: the load is discarded.
        if (RESET_N) async_reset("rst_pre_load");
        @(negedge CLK);
        LOAD = 1'b1; LOAD_VAL = 4'd7; EN = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_over_load", 0, 0);
        release_reset();

        // Random mix with the model.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
